seq_mul16: RTL and testbench
============================

SEQ_MUL16 -- requirements
Module: seq_mul16

Interface
REQ-001 Parameter: none; data width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  16  multiplicand; captured on accepted start.
REQ-006 b  input  16  multiplier; captured on accepted start.
REQ-007 out  output  16  low 16 bits of a*b; registered; held until next completion.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse, high only in DONE.

Function
REQ-010 The block SHALL be a shift-add multiplier with states IDLE, RUN, DONE.
REQ-011 IDLE: start=1 at an edge SHALL load mcand<=a, mplier<=b, acc<=0, count<=0, next state RUN; start=0 SHALL keep IDLE.
REQ-012 RUN, each edge: if mplier[0]=1, acc<=acc+mcand (16-bit, carry out discarded), else acc unchanged; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-013 RUN SHALL last exactly 16 edges; on the edge where count=15, out<=final acc value and next state DONE.
REQ-014 Latency: start accepted at edge k SHALL give done=1 and valid out in the cycle following edge k+16; fixed, independent of operand values (no early exit when mplier=0).
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-016 start SHALL be ignored in RUN and DONE; a, b SHALL be ignored except at the accepting edge.
REQ-017 Earliest back-to-back accept: start at the edge leaving DONE is ignored; next accepted start is the first edge with state IDLE.
REQ-018 Product SHALL equal (a*b) mod 2^16; result is correct for both unsigned and two's-complement operands.
REQ-019 out SHALL change only at the edge entering DONE (or reset); it SHALL NOT show partial sums.
REQ-020 busy and done SHALL be mutually exclusive; both low in IDLE.

Reset
REQ-021 rst_n=0 at an edge SHALL force state IDLE, out=0, busy=0, done=0, acc=0, mcand=0, mplier=0, count=0.
REQ-022 Reset during RUN or DONE SHALL abort the operation with no done pulse and out=0.
REQ-023 start asserted in the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-024 Shared header SHALL hold state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), WIDTH=16 and the iteration count 16.
REQ-025 Accumulation SHALL use one instance of the existing Add16 module (inputs acc, mcand; output next-acc); no behavioural "+" for the accumulate path.
REQ-026 Unused state encoding 2'd3 SHALL transition to IDLE.

Verification
REQ-027 a=0x0003, b=0x0005, start at edge k -> busy high edges k+1..k+16, done=1 after edge k+16, out=0x000F.
REQ-028 a=0xFFFF, b=0xFFFF -> out=0x0001; a=0x0100, b=0x0100 -> out=0x0000 (truncation).
REQ-029 a=0xFFFD (-3), b=0x0007 -> out=0xFFEB (-21); a=0x1234, b=0x0000 -> out=0x0000 with same 17-cycle latency.
REQ-030 start with a=2,b=3, then start with a=9,b=9 held during RUN and DONE -> single done, out=0x0006; next start accepted in IDLE yields 0x0051.
REQ-031 start a=7,b=7, rst_n=0 at edge k+8 -> no done pulse, out=0x0000, busy=0; following start a=4,b=4 -> out=0x0010 after full latency.
REQ-032 Random a,b (>=1000 pairs) vs. reference model (a*b)&0xFFFF; check done width = 1 cycle and out stable between completions.

Source files
------------

// File: rtl/seq_mul16_pkg.sv
// Shared definitions for the 16-bit sequential shift-add multiplier:
// state encodings, datapath width and iteration count.
package seq_mul16_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned ITERATIONS = 16;
  localparam int unsigned COUNT_W    = $clog2(ITERATIONS);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITERATIONS - 1);

  // Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul16_if.sv
// Request/response bundle of seq_mul16: operands and start in,
// product with busy/done status out.
interface seq_mul16_if;
  import seq_mul16_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  out, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, busy, done
  );

endinterface

// File: rtl/Add16.sv
// 16-bit adder used for the accumulate path; carry out is discarded so
// the sum wraps modulo 2^16.
module Add16
  import seq_mul16_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/seq_mul16.sv
// Sequential shift-add multiplier: 16 RUN cycles per product, fixed
// latency, low 16 bits of a*b presented on out with a one-cycle done pulse.
module seq_mul16
  import seq_mul16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  seq_mul16_if.slave  bus
);

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic [COUNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0]   out_q,    out_d;
  logic [WIDTH-1:0]   add_sum;

  Add16 u_add16 (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    out_d    = out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (mplier_q[0]) begin
          acc_d = add_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + COUNT_W'(1);
        // The last step's partial product goes straight to out so the
        // result lands on the same edge that enters DONE.
        if (count_q == LAST_COUNT) begin
          out_d   = acc_d;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_mul16.sv
// Scoreboard bench for seq_mul16: the driver queues expected products with
// their accept cycle, the monitor checks each done pulse and out stability.
module tb_seq_mul16;

  logic clk = 1'b0;
  logic rst_n;

  seq_mul16_if bus ();

  seq_mul16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  logic        rst_seen = 1'b0;
  int          checks_total = 0;
  int          checks_passed = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor
  initial begin : monitor
    logic [15:0] last_out;
    logic        prev_done;
    exp_t        e;
    last_out  = '0;
    prev_done = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_seen) begin
        check("reset_out",  {16'h0, bus.out}, 32'h0);
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_done", {31'h0, bus.done}, 32'h0);
        last_out  = '0;
        prev_done = 1'b0;
      end else begin
        check("busy_done_excl", {31'h0, bus.busy & bus.done}, 32'h0);
        if (bus.done) begin
          check("done_width", {31'h0, prev_done}, 32'h0);
          if (sb.size() == 0) begin
            checks_total++;
            $display("FAIL unexpected_done: got done=1 out=%0h expected no pending op (cycle %0d)", bus.out, cyc);
          end else begin
            e = sb.pop_front();
            check("product", {16'h0, bus.out}, {16'h0, e.exp});
            check("latency", cyc - e.acc_cyc, 32'd16);
          end
          last_out = bus.out;
        end else begin
          check("out_hold", {16'h0, bus.out}, {16'h0, last_out});
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic push, input logic [15:0] exp);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    e.exp     = exp;
    e.acc_cyc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'hDEAD;
    bus.b     = 16'hBEEF;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t        e;
    logic        seen;
    logic [15:0] ra, rb;
    logic [31:0] prod;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_in_reset_busy", {31'h0, bus.busy}, 32'h0);

    // 3*5 with busy window: busy after edges k..k+15, done after k+16
    start_op(16'h0003, 16'h0005, 1'b1, 16'h000F);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("busy_window", {31'h0, bus.busy}, 32'h1);
    end
    @(negedge clk);
    check("done_after_16", {31'h0, bus.done}, 32'h1);

    start_op(16'hFFFF, 16'hFFFF, 1'b1, 16'h0001);
    start_op(16'h0100, 16'h0100, 1'b1, 16'h0000);
    start_op(16'hFFFD, 16'h0007, 1'b1, 16'hFFEB);
    start_op(16'h1234, 16'h0000, 1'b1, 16'h0000);
    start_op(16'hFFFF, 16'h0001, 1'b1, 16'hFFFF);
    start_op(16'h8000, 16'h0002, 1'b1, 16'h0000);

    // start held high through RUN and DONE with new operands
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 16'd2;
    bus.b     = 16'd3;
    e.exp     = 16'h0006;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.a = 16'd9;
    bus.b = 16'd9;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_start_done_seen", {31'h0, seen}, 32'h1);
    e.exp     = 16'h0051;
    e.acc_cyc = cyc + 2;
    sb.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;

    // reset mid-RUN aborts with no done pulse
    start_op(16'd7, 16'd7, 1'b0, 16'h0000);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);
    check("abort_out", {16'h0, bus.out}, 32'h0);
    start_op(16'd4, 16'd4, 1'b1, 16'h0010);

    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      prod = {16'h0, ra} * {16'h0, rb};
      start_op(ra, rb, 1'b1, prod[15:0]);
    end

    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
